// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: FSM encodings and
// the layout of one scoreboard entry.
package hazard_pkg;
  localparam int SB_REG_W   = 3;
  localparam int SB_ENTRY_W = SB_REG_W + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rsel;
  } sb_entry_t;
endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Flags a source select that matches an in-flight destination in EX or MEM.
module sb_match
  import hazard_pkg::*;
(
  input  logic [SB_REG_W-1:0] sel_i,
  input  sb_entry_t           sb_ex_i,
  input  sb_entry_t           sb_mem_i,
  output logic                hit_o
);
  assign hit_o = (sb_ex_i.valid  && (sb_ex_i.rsel  == sel_i)) ||
                 (sb_mem_i.valid && (sb_mem_i.rsel == sel_i));
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW stall via a two-entry scoreboard,
// branch flush, memory freeze and a HALT drain sequence.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       readReg1,
  input  logic [2:0]       readReg2,
  input  logic             id_uses_r1,
  input  logic             id_uses_r2,
  input  logic [2:0]       writeReg,
  input  logic             id_RegWrite,
  input  logic             id_createdump,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count
);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t           state_q, state_d;
  sb_entry_t        sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             halt_q;
  logic             hit1, hit2, raw_hazard;

  sb_match u_match_r1 (.sel_i(readReg1), .sb_ex_i(sb_ex_q), .sb_mem_i(sb_mem_q), .hit_o(hit1));
  sb_match u_match_r2 (.sel_i(readReg2), .sb_ex_i(sb_ex_q), .sb_mem_i(sb_mem_q), .hit_o(hit2));

  assign raw_hazard = id_valid & ((id_uses_r1 & hit1) | (id_uses_r2 & hit2));

  always_comb begin
    state_d       = state_q;
    sb_ex_d       = sb_ex_q;
    sb_mem_d      = sb_mem_q;
    drain_d       = drain_q;
    stall_d       = stall_q;
    pc_write_en   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            // whole pipe frozen: nothing moves
          end else if (ex_branch_taken) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            sb_ex_d       = '0;
            sb_mem_d      = sb_ex_q;
          end else if (raw_hazard) begin
            idex_bubble = 1'b1;
            sb_ex_d     = '0;
            sb_mem_d    = sb_ex_q;
            if (~&stall_q) stall_d = stall_q + CNT_W'(1);
          end else begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            sb_ex_d.valid = id_valid & id_RegWrite;
            sb_ex_d.rsel  = writeReg;
            sb_mem_d      = sb_ex_q;
            if (id_valid && id_createdump) begin
              state_d = DRAIN;
              drain_d = DW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          idex_bubble = 1'b1;
          if (!mem_stall) begin
            sb_ex_d  = '0;
            sb_mem_d = sb_ex_q;
            if (drain_q <= DW'(1)) begin
              state_d = HALTED;
              drain_d = '0;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        HALTED: begin
          idex_bubble = 1'b1;
          sb_ex_d     = '0;
          sb_mem_d    = sb_ex_q;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      drain_q  <= '0;
      stall_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      halt_q   <= (state_d == HALTED);
    end
  end

  assign halt        = halt_q;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second, 2-bit-counter instance shares
// the stimulus so the saturation boundary is reachable in a few cycles.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_r1, id_uses_r2, id_RegWrite, id_createdump;
  logic        ex_branch_taken, mem_stall;
  logic [2:0]  readReg1, readReg2, writeReg;
  logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble, halt;
  logic [15:0] stall_count;
  logic        n_pc, n_ifid, n_flush, n_bubble, n_halt;
  logic [1:0]  n_stall;
  logic [3:0]  ctl;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  assign ctl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble};

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .readReg1(readReg1), .readReg2(readReg2),
    .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2), .writeReg(writeReg),
    .id_RegWrite(id_RegWrite), .id_createdump(id_createdump),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .halt(halt), .stall_count(stall_count));

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .readReg1(readReg1), .readReg2(readReg2),
    .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2), .writeReg(writeReg),
    .id_RegWrite(id_RegWrite), .id_createdump(id_createdump),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_write_en(n_pc), .ifid_write_en(n_ifid), .ifid_flush(n_flush),
    .idex_bubble(n_bubble), .halt(n_halt), .stall_count(n_stall));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic v, input logic [2:0] r1, input logic u1,
                       input logic [2:0] r2, input logic u2,
                       input logic [2:0] wr, input logic rw, input logic dmp);
    id_valid = v; readReg1 = r1; id_uses_r1 = u1; readReg2 = r2; id_uses_r2 = u2;
    writeReg = wr; id_RegWrite = rw; id_createdump = dmp;
    #1;
  endtask

  task automatic idle;
    instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1; ex_branch_taken = 1'b0; mem_stall = 1'b0;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ex_branch_taken = 1'b0; mem_stall = 1'b0;
    idle();
    checks++; if (ctl !== 4'b0011) begin errs++; $display("FAIL reset_ctl: got %b exp %b", ctl, 4'b0011); end
    tick();
    checks++; if (halt !== 1'b0) begin errs++; $display("FAIL reset_halt: got %b exp 0", halt); end
    checks++; if (stall_count !== 16'd0) begin errs++; $display("FAIL reset_cnt: got %0d exp 0", stall_count); end
    rst = 1'b0; #1;
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL reset_run_ctl: got %b exp %b", ctl, 4'b1100); end
  endtask

  task automatic test_raw_back_to_back;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);  // ADD -> R3
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL b2b_add_issue: got %b exp %b", ctl, 4'b1100); end
    tick();
    instr(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);  // SUB reads R3
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL b2b_stall1: got %b exp %b", ctl, 4'b0001); end
    tick();
    checks++; if (stall_count !== 16'd1) begin errs++; $display("FAIL b2b_cnt1: got %0d exp 1", stall_count); end
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL b2b_stall2: got %b exp %b", ctl, 4'b0001); end
    tick();
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL b2b_sub_issue: got %b exp %b", ctl, 4'b1100); end
    tick();
    checks++; if (stall_count !== 16'd2) begin errs++; $display("FAIL b2b_cnt2: got %0d exp 2", stall_count); end
  endtask

  task automatic test_one_gap;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    instr(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);  // unrelated
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL gap_unrelated: got %b exp %b", ctl, 4'b1100); end
    tick();
    instr(1'b1, 3'd6, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 1'b0);  // reads R3 on port 2
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL gap_stall: got %b exp %b", ctl, 4'b0001); end
    tick();
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL gap_issue: got %b exp %b", ctl, 4'b1100); end
    tick();
    checks++; if (stall_count !== 16'd1) begin errs++; $display("FAIL gap_cnt: got %0d exp 1", stall_count); end
  endtask

  task automatic test_gating;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    instr(1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 3'd2, 1'b0, 1'b0);  // names R3 but reads nothing
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL gate_uses: got %b exp %b", ctl, 4'b1100); end
    tick();
    instr(1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);  // bubble, R3 still in MEM
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL gate_valid: got %b exp %b", ctl, 4'b1100); end
    tick();
    instr(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);  // R2 never written
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL gate_regwrite: got %b exp %b", ctl, 4'b1100); end
    tick();
    checks++; if (stall_count !== 16'd0) begin errs++; $display("FAIL gate_cnt: got %0d exp 0", stall_count); end
  endtask

  task automatic test_branch_over_raw;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    ex_branch_taken = 1'b1;
    instr(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    checks++; if (ctl !== 4'b1111) begin errs++; $display("FAIL br_ctl: got %b exp %b", ctl, 4'b1111); end
    tick();
    checks++; if (stall_count !== 16'd0) begin errs++; $display("FAIL br_cnt: got %0d exp 0", stall_count); end
    ex_branch_taken = 1'b0; #1;
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL br_shifted_mem: got %b exp %b", ctl, 4'b0001); end
    tick();
  endtask

  task automatic test_mem_freeze;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    instr(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== 4'b0000) begin errs++; $display("FAIL ms_ctl[%0d]: got %b exp %b", i, ctl, 4'b0000); end
      tick();
    end
    checks++; if (stall_count !== 16'd1) begin errs++; $display("FAIL ms_cnt_hold: got %0d exp 1", stall_count); end
    mem_stall = 1'b0; #1;
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL ms_resume: got %b exp %b", ctl, 4'b0001); end
    tick();
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL ms_issue: got %b exp %b", ctl, 4'b1100); end
    checks++; if (stall_count !== 16'd2) begin errs++; $display("FAIL ms_cnt: got %0d exp 2", stall_count); end
  endtask

  task automatic test_halt;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL halt_issue: got %b exp %b", ctl, 4'b1100); end
    tick();
    ex_branch_taken = 1'b1;  // must be ignored while draining
    idle();
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL drain_ctl: got %b exp %b", ctl, 4'b0001); end
    tick(); tick();
    checks++; if (halt !== 1'b0) begin errs++; $display("FAIL halt_early: got %b exp 0", halt); end
    tick();
    checks++; if (halt !== 1'b1) begin errs++; $display("FAIL halt_at3: got %b exp 1", halt); end
    checks++; if (ctl !== 4'b0001) begin errs++; $display("FAIL halted_ctl: got %b exp %b", ctl, 4'b0001); end
    tick(); tick();
    checks++; if (halt !== 1'b1) begin errs++; $display("FAIL halt_sticky: got %b exp 1", halt); end
    ex_branch_taken = 1'b0;
    do_reset();
    checks++; if (halt !== 1'b0) begin errs++; $display("FAIL halt_clear: got %b exp 0", halt); end
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL halt_run_again: got %b exp %b", ctl, 4'b1100); end
  endtask

  task automatic test_drain_corners;
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    idle();
    mem_stall = 1'b1;
    tick();
    mem_stall = 1'b0;
    tick(); tick();
    checks++; if (halt !== 1'b0) begin errs++; $display("FAIL drain_ms_early: got %b exp 0", halt); end
    tick();
    checks++; if (halt !== 1'b1) begin errs++; $display("FAIL drain_ms_halt: got %b exp 1", halt); end
    do_reset();
    instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    do_reset();  // reset mid-drain
    for (int i = 0; i < 4; i++) tick();
    checks++; if (halt !== 1'b0) begin errs++; $display("FAIL drain_rst_halt: got %b exp 0", halt); end
    checks++; if (ctl !== 4'b1100) begin errs++; $display("FAIL drain_rst_ctl: got %b exp %b", ctl, 4'b1100); end
  endtask

  task automatic test_saturation;
    do_reset();
    // every instruction reads and writes R1: issue, stall, stall, issue, ...
    instr(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick(); tick(); tick();
    checks++; if (n_stall !== 2'd2) begin errs++; $display("FAIL sat_pre: got %0d exp 2", n_stall); end
    tick(); tick(); tick();
    checks++; if (stall_count !== 16'd4) begin errs++; $display("FAIL sat_wide4: got %0d exp 4", stall_count); end
    tick(); tick();
    checks++; if (n_stall !== 2'd3) begin errs++; $display("FAIL sat_hold: got %0d exp 3", n_stall); end
    checks++; if (stall_count !== 16'd5) begin errs++; $display("FAIL sat_wide5: got %0d exp 5", stall_count); end
  endtask

  initial begin
    test_reset();
    test_raw_back_to_back();
    test_one_gap();
    test_gating();
    test_branch_over_raw();
    test_mem_freeze();
    test_halt();
    test_drain_corners();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles to hold after the halt issues so it reaches WB.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode holds a real instruction, not a bubble.
REQ-006 readReg1, readReg2  in  3 each  decode source selects.
REQ-007 id_uses_r1, id_uses_r2  in  1 each  the source is actually read.
REQ-008 writeReg  in  3  decode destination select.
REQ-009 id_RegWrite  in  1  decode instruction writes the register file.
REQ-010 id_createdump  in  1  decode instruction is HALT.
REQ-011 ex_branch_taken  in  1  a branch or jump resolved taken in EX this cycle.
REQ-012 mem_stall  in  1  the memory stage is busy; the whole pipe freezes.
REQ-013 pc_write_en  out  1  PC may advance.
REQ-014 ifid_write_en  out  1  the IF/ID register may load.
REQ-015 ifid_flush  out  1  IF/ID loads a bubble.
REQ-016 idex_bubble  out  1  ID/EX loads a NOP (no RegWrite, MemWrite or branch).
REQ-017 halt  out  1  the processor has halted; sticky.
REQ-018 stall_count  out  CNT_W  count of cycles with idex_bubble=1 due to a RAW hazard.

Function
REQ-019 The scoreboard SHALL hold two registered entries, sb_ex and sb_mem, each {valid, reg[2:0]}; WB is excluded because the register file bypasses writes to same-cycle reads.
REQ-020 raw_hazard SHALL be id_valid & ((id_uses_r1 & match(readReg1)) | (id_uses_r2 & match(readReg2))), where match(r) is (sb_ex.valid & sb_ex.reg==r) | (sb_mem.valid & sb_mem.reg==r).
REQ-021 Priority SHALL be, highest first: rst > mem_stall > ex_branch_taken > raw_hazard > normal issue.
REQ-022 The FSM SHALL have the states RUN, DRAIN, HALTED, encoded in 2 bits.
REQ-023 RUN, mem_stall=1: all outputs SHALL be 0 except halt; the scoreboard, FSM state and counter SHALL hold.
REQ-024 RUN, ex_branch_taken=1: pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_bubble=1; sb_ex<=0 and sb_mem<=sb_ex.
REQ-025 RUN, raw_hazard=1: pc_write_en=0, ifid_write_en=0, idex_bubble=1; sb_ex<=0, sb_mem<=sb_ex, stall_count+1.
REQ-026 RUN, otherwise: pc_write_en=1, ifid_write_en=1, idex_bubble=0; sb_ex<={id_valid&id_RegWrite, writeReg}, sb_mem<=sb_ex.
REQ-027 If the issuing instruction in REQ-026 has id_createdump=1, the next state SHALL be DRAIN and the drain counter SHALL load DRAIN_CYCLES.
REQ-028 DRAIN: pc_write_en=0, ifid_write_en=0, idex_bubble=1; scoreboard shifts; the counter decrements unless mem_stall=1; at 1, the next state SHALL be HALTED.
REQ-029 HALTED: halt=1, pc_write_en=0, ifid_write_en=0, idex_bubble=1, held until rst.
REQ-030 In DRAIN and HALTED, ex_branch_taken SHALL be ignored.
REQ-031 stall_count SHALL saturate at all-ones and never wrap.
REQ-032 All outputs except stall_count and halt SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-033 On a rst=1 clock edge: state=RUN, sb_ex=sb_mem=0, drain counter=0, stall_count=0, halt=0.
REQ-034 While rst=1: pc_write_en=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1.
REQ-035 A reset asserted in DRAIN or HALTED SHALL return the block to RUN with no residual state.

Structure
REQ-036 The state encodings (RUN=0, DRAIN=1, HALTED=2) and the scoreboard-entry width SHALL live in a shared package, hazard_pkg.
REQ-037 One sub-module, sb_match, SHALL compare a 3-bit select against both scoreboard entries; it is instantiated twice.

Verification
REQ-038 Issue ADD writing R3, then SUB reading R3 next cycle -> idex_bubble=1 for 2 cycles, stall_count=2, SUB issues in cycle 3.
REQ-039 Writer of R3, then one unrelated instruction, then reader of R3 -> exactly 1 stall cycle.
REQ-040 raw_hazard and ex_branch_taken high together -> ifid_flush=1, pc_write_en=1, stall_count unchanged.
REQ-041 mem_stall=1 for 4 cycles during a pending hazard -> scoreboard frozen; the stall resumes its count after release.
REQ-042 HALT issued with DRAIN_CYCLES=3 -> halt=1 exactly 3 cycles after DRAIN entry; rst then clears halt and state to RUN.
REQ-043 Force stall_count=16'hFFFE, then cause 3 hazard cycles -> stall_count reads 16'hFFFF.
